// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared widths, pending-entry payload and drain-select encoding for the regfile writeback arbiter.
package regfile_wb_arbiter_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned REG_AW   = 5;
    localparam int unsigned NUM_REGS = 32;
    localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] addr;
        logic [XLEN-1:0]   data;
    } wb_entry_t;

    typedef enum logic [1:0] {
        SEL_NONE,
        SEL_PORT0,
        SEL_PORT1,
        SEL_DROP
    } drain_sel_t;

    function automatic logic addr_hit(input logic en,
                                      input logic [REG_AW-1:0] a,
                                      input logic [REG_AW-1:0] b);
        return en && (a == b);
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_pending_fifo.sv
// In-order queue of long-latency writes; entries can be invalidated by address while queued.
module wb_pending_fifo
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                push,
    input  wb_entry_t           push_entry,
    input  logic                pop,
    input  logic                kill0_en,
    input  logic [REG_AW-1:0]   kill0_addr,
    input  logic                kill1_en,
    input  logic [REG_AW-1:0]   kill1_addr,
    output logic                empty,
    output logic                full,
    output logic                head_valid,
    output logic [REG_AW-1:0]   head_addr,
    output logic [XLEN-1:0]     head_data,
    output logic [NUM_REGS-1:0] busy_mask
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    wb_entry_t          mem [DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   count;

    // Kill is applied first so a same-cycle push to a killed address still lands valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i].valid <= 1'b0;
            end
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (addr_hit(kill0_en, mem[i].addr, kill0_addr) ||
                    addr_hit(kill1_en, mem[i].addr, kill1_addr)) begin
                    mem[i].valid <= 1'b0;
                end
            end
            if (pop) begin
                mem[rd_ptr].valid <= 1'b0;
                rd_ptr            <= rd_ptr + PTR_W'(1);
            end
            if (push) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_comb begin
        empty      = (count == '0);
        full       = (count == CNT_W'(DEPTH));
        head_valid = !empty && mem[rd_ptr].valid;
        head_addr  = mem[rd_ptr].addr;
        head_data  = mem[rd_ptr].data;
    end

    // Slots outside the occupied window are always invalid, so decode every slot.
    always_comb begin
        busy_mask = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (mem[i].valid) begin
                busy_mask[mem[i].addr] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Schedules pipe writebacks and queued long-latency results onto the two regfile write ports.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned MAX_WAIT = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pipe_wen0,
    input  logic [REG_AW-1:0]   pipe_waddr0,
    input  logic [XLEN-1:0]     pipe_wdata0,
    input  logic                pipe_wen1,
    input  logic [REG_AW-1:0]   pipe_waddr1,
    input  logic [XLEN-1:0]     pipe_wdata1,
    input  logic                lu_valid,
    output logic                lu_ready,
    input  logic [REG_AW-1:0]   lu_waddr,
    input  logic [XLEN-1:0]     lu_wdata,
    output logic                rf_wen0,
    output logic [REG_AW-1:0]   rf_waddr0,
    output logic [XLEN-1:0]     rf_wdata0,
    output logic                rf_wen1,
    output logic [REG_AW-1:0]   rf_waddr1,
    output logic [XLEN-1:0]     rf_wdata1,
    output logic [NUM_REGS-1:0] pend_busy,
    output logic                wb_stall
);

    localparam int unsigned AGE_W = $clog2(MAX_WAIT + 1);

    logic              pipe_live0;
    logic              pipe_live1;
    logic              head_live;
    logic              fifo_empty;
    logic              fifo_full;
    logic              head_valid;
    logic [REG_AW-1:0] head_addr;
    logic [XLEN-1:0]   head_data;
    logic              push;
    logic              pop;
    logic              blocked;
    wb_entry_t         push_entry;
    drain_sel_t        sel;
    logic [AGE_W-1:0]  age;

    // r0 writes vanish; a pipe1 write shadowed by pipe0 to the same register is dropped.
    always_comb begin
        pipe_live0 = pipe_wen0 && (pipe_waddr0 != REG_ZERO);
        pipe_live1 = pipe_wen1 && (pipe_waddr1 != REG_ZERO) &&
                     !addr_hit(pipe_live0, pipe_waddr1, pipe_waddr0);
        head_live  = head_valid &&
                     !addr_hit(pipe_live0, head_addr, pipe_waddr0) &&
                     !addr_hit(pipe_live1, head_addr, pipe_waddr1);
    end

    // A head overwritten by this cycle's pipe write is retired without using a port.
    always_comb begin
        sel = SEL_NONE;
        if (!fifo_empty) begin
            if (!head_live) begin
                sel = SEL_DROP;
            end else if (!pipe_live0) begin
                sel = SEL_PORT0;
            end else if (!pipe_live1) begin
                sel = SEL_PORT1;
            end
        end
        pop     = (sel != SEL_NONE);
        blocked = !fifo_empty && (sel == SEL_NONE);
    end

    always_comb begin
        rf_wen0   = !rst && (pipe_live0 || (sel == SEL_PORT0));
        rf_waddr0 = pipe_live0 ? pipe_waddr0 : head_addr;
        rf_wdata0 = pipe_live0 ? pipe_wdata0 : head_data;
        rf_wen1   = !rst && (pipe_live1 || (sel == SEL_PORT1));
        rf_waddr1 = pipe_live1 ? pipe_waddr1 : head_addr;
        rf_wdata1 = pipe_live1 ? pipe_wdata1 : head_data;
    end

    always_comb begin
        lu_ready   = !rst && !fifo_full;
        push       = lu_valid && lu_ready && (lu_waddr != REG_ZERO);
        push_entry = '{valid: 1'b1, addr: lu_waddr, data: lu_wdata};
    end

    wb_pending_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .kill0_en   (pipe_live0),
        .kill0_addr (pipe_waddr0),
        .kill1_en   (pipe_live1),
        .kill1_addr (pipe_waddr1),
        .empty      (fifo_empty),
        .full       (fifo_full),
        .head_valid (head_valid),
        .head_addr  (head_addr),
        .head_data  (head_data),
        .busy_mask  (pend_busy)
    );

    // Age saturates at MAX_WAIT-1; the stall holds until the head finally leaves.
    always_ff @(posedge clk) begin
        if (rst) begin
            age      <= '0;
            wb_stall <= 1'b0;
        end else if (blocked) begin
            if (age == AGE_W'(MAX_WAIT - 1)) begin
                wb_stall <= 1'b1;
            end else begin
                age <= age + AGE_W'(1);
            end
        end else begin
            age      <= '0;
            wb_stall <= 1'b0;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed vector table, hand sequences and a queue-based random model.
module tb_regfile_wb_arbiter;

    localparam int DEPTH    = 4;
    localparam int MAX_WAIT = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        pipe_wen0, pipe_wen1, lu_valid;
    logic [4:0]  pipe_waddr0, pipe_waddr1, lu_waddr;
    logic [31:0] pipe_wdata0, pipe_wdata1, lu_wdata;
    logic        lu_ready, rf_wen0, rf_wen1, wb_stall;
    logic [4:0]  rf_waddr0, rf_waddr1;
    logic [31:0] rf_wdata0, rf_wdata1, pend_busy;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst(rst),
        .pipe_wen0(pipe_wen0), .pipe_waddr0(pipe_waddr0), .pipe_wdata0(pipe_wdata0),
        .pipe_wen1(pipe_wen1), .pipe_waddr1(pipe_waddr1), .pipe_wdata1(pipe_wdata1),
        .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_waddr(lu_waddr), .lu_wdata(lu_wdata),
        .rf_wen0(rf_wen0), .rf_waddr0(rf_waddr0), .rf_wdata0(rf_wdata0),
        .rf_wen1(rf_wen1), .rf_waddr1(rf_waddr1), .rf_wdata1(rf_wdata1),
        .pend_busy(pend_busy), .wb_stall(wb_stall)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a queue of pending writes in program order.
    typedef struct {
        logic        v;
        logic [4:0]  a;
        logic [31:0] d;
    } ment_t;

    ment_t       mq[$];
    int          m_age;
    bit          m_stall;
    bit          m_p0, m_p1, m_drop, m_blocked;
    int          m_port;
    logic        e_ready, e_wen0, e_wen1, e_stall;
    logic [4:0]  e_a0, e_a1;
    logic [31:0] e_d0, e_d1, e_pend;
    logic [31:0] mdl_rf [32];
    logic [31:0] obs_rf [32];

    task automatic model_eval();
        bit live;
        e_ready = !rst && (mq.size() < DEPTH);
        e_stall = m_stall;
        e_pend  = '0;
        foreach (mq[i]) if (mq[i].v) e_pend[mq[i].a] = 1'b1;
        m_p0 = pipe_wen0 && (pipe_waddr0 != 5'd0);
        m_p1 = pipe_wen1 && (pipe_waddr1 != 5'd0) && !(m_p0 && pipe_waddr1 == pipe_waddr0);
        m_port = -1; m_drop = 0; m_blocked = 0;
        if (mq.size() > 0) begin
            live = mq[0].v && !(m_p0 && mq[0].a == pipe_waddr0) && !(m_p1 && mq[0].a == pipe_waddr1);
            if (!live)      m_drop = 1;
            else if (!m_p0) m_port = 0;
            else if (!m_p1) m_port = 1;
            else            m_blocked = 1;
        end
        e_wen0 = !rst && (m_p0 || m_port == 0);
        e_wen1 = !rst && (m_p1 || m_port == 1);
        e_a0 = '0; e_d0 = '0; e_a1 = '0; e_d1 = '0;
        if (m_p0) begin e_a0 = pipe_waddr0; e_d0 = pipe_wdata0; end
        else if (m_port == 0) begin e_a0 = mq[0].a; e_d0 = mq[0].d; end
        if (m_p1) begin e_a1 = pipe_waddr1; e_d1 = pipe_wdata1; end
        else if (m_port == 1) begin e_a1 = mq[0].a; e_d1 = mq[0].d; end
    endtask

    task automatic model_commit();
        if (rst) begin
            mq.delete();
            m_age = 0;
            m_stall = 0;
        end else begin
            if (e_wen0) mdl_rf[e_a0] = e_d0;
            if (e_wen1) mdl_rf[e_a1] = e_d1;
            foreach (mq[i])
                if ((m_p0 && mq[i].a == pipe_waddr0) || (m_p1 && mq[i].a == pipe_waddr1)) mq[i].v = 1'b0;
            if (m_drop || m_port >= 0) void'(mq.pop_front());
            if (lu_valid && e_ready && lu_waddr != 5'd0) mq.push_back('{1'b1, lu_waddr, lu_wdata});
            if (m_blocked) begin
                if (m_age == MAX_WAIT - 1) m_stall = 1;
                else m_age++;
            end else begin
                m_age = 0;
                m_stall = 0;
            end
        end
    endtask

    task automatic drive(input int r, input int w0, input int a0, input int d0,
                         input int w1, input int a1, input int d1,
                         input int lv, input int la, input int ld);
        rst = 1'(r);
        pipe_wen0 = 1'(w0); pipe_waddr0 = 5'(a0); pipe_wdata0 = 32'(d0);
        pipe_wen1 = 1'(w1); pipe_waddr1 = 5'(a1); pipe_wdata1 = 32'(d1);
        lu_valid = 1'(lv); lu_waddr = 5'(la); lu_wdata = 32'(ld);
    endtask

    // Sample point: 2ns after the falling edge, well clear of the rising edge.
    task automatic pre();
        #2;
        model_eval();
        if (rf_wen0 === 1'b1) obs_rf[rf_waddr0] = rf_wdata0;
        if (rf_wen1 === 1'b1) obs_rf[rf_waddr1] = rf_wdata1;
    endtask

    task automatic post();
        @(posedge clk);
        model_commit();
        @(negedge clk);
    endtask

    task automatic chk_model();
        chk("rnd lu_ready", 32'(lu_ready), 32'(e_ready));
        chk("rnd rf_wen0", 32'(rf_wen0), 32'(e_wen0));
        if (e_wen0) begin
            chk("rnd rf_waddr0", 32'(rf_waddr0), 32'(e_a0));
            chk("rnd rf_wdata0", rf_wdata0, e_d0);
        end
        chk("rnd rf_wen1", 32'(rf_wen1), 32'(e_wen1));
        if (e_wen1) begin
            chk("rnd rf_waddr1", 32'(rf_waddr1), 32'(e_a1));
            chk("rnd rf_wdata1", rf_wdata1, e_d1);
        end
        chk("rnd pend_busy", pend_busy, e_pend);
        chk("rnd wb_stall", 32'(wb_stall), 32'(e_stall));
    endtask

    typedef struct {
        int pw0, pa0, pd0, pw1, pa1, pd1, lv, la, ld;
        int x_ready, x_wen0, x_a0, x_d0, x_wen1, x_a1, x_d1, x_pend;
    } vec_t;

    vec_t vt [24];

    task automatic run_rows(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            drive(0, vt[i].pw0, vt[i].pa0, vt[i].pd0, vt[i].pw1, vt[i].pa1, vt[i].pd1,
                  vt[i].lv, vt[i].la, vt[i].ld);
            pre();
            chk($sformatf("vec%0d lu_ready", i), 32'(lu_ready), 32'(vt[i].x_ready));
            chk($sformatf("vec%0d rf_wen0", i), 32'(rf_wen0), 32'(vt[i].x_wen0));
            if (vt[i].x_wen0 != 0) begin
                chk($sformatf("vec%0d rf_waddr0", i), 32'(rf_waddr0), 32'(vt[i].x_a0));
                chk($sformatf("vec%0d rf_wdata0", i), rf_wdata0, 32'(vt[i].x_d0));
            end
            chk($sformatf("vec%0d rf_wen1", i), 32'(rf_wen1), 32'(vt[i].x_wen1));
            if (vt[i].x_wen1 != 0) begin
                chk($sformatf("vec%0d rf_waddr1", i), 32'(rf_waddr1), 32'(vt[i].x_a1));
                chk($sformatf("vec%0d rf_wdata1", i), rf_wdata1, 32'(vt[i].x_d1));
            end
            chk($sformatf("vec%0d pend_busy", i), pend_busy, 32'(vt[i].x_pend));
            chk($sformatf("vec%0d wb_stall", i), 32'(wb_stall), 32'(0));
            post();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //        pw0 pa0 pd0     pw1 pa1 pd1    lv la ld       rdy w0 a0 d0       w1 a1 d1         pend
        vt[0]  = '{1, 5, 'h11,    1, 5, 'h22,   0, 0, 0,        1,  1, 5, 'h11,    0, 0, 0,         0};
        vt[1]  = '{1, 0, 'h33,    0, 0, 0,      0, 0, 0,        1,  0, 0, 0,       0, 0, 0,         0};
        vt[2]  = '{0, 0, 0,       0, 0, 0,      1, 7, 'hDEAD,   1,  0, 0, 0,       0, 0, 0,         0};
        vt[3]  = '{1, 1, 'h1,     0, 0, 0,      0, 0, 0,        1,  1, 1, 'h1,     1, 7, 'hDEAD,    'h80};
        vt[4]  = '{0, 0, 0,       0, 0, 0,      0, 0, 0,        1,  0, 0, 0,       0, 0, 0,         0};
        vt[5]  = '{1, 1, 'hA1,    1, 2, 'hB2,   1, 10, 'h100,   1,  1, 1, 'hA1,    1, 2, 'hB2,      0};
        vt[6]  = '{1, 1, 'hA1,    1, 2, 'hB2,   1, 11, 'h101,   1,  1, 1, 'hA1,    1, 2, 'hB2,      'h400};
        vt[7]  = '{1, 1, 'hA1,    1, 2, 'hB2,   1, 12, 'h102,   1,  1, 1, 'hA1,    1, 2, 'hB2,      'hC00};
        vt[8]  = '{1, 1, 'hA1,    1, 2, 'hB2,   1, 13, 'h103,   1,  1, 1, 'hA1,    1, 2, 'hB2,      'h1C00};
        vt[9]  = '{1, 1, 'hA1,    1, 2, 'hB2,   1, 14, 'h104,   0,  1, 1, 'hA1,    1, 2, 'hB2,      'h3C00};
        vt[10] = '{0, 0, 0,       1, 2, 'hB2,   1, 14, 'h104,   0,  1, 10, 'h100,  1, 2, 'hB2,      'h3C00};
        vt[11] = '{0, 0, 0,       0, 0, 0,      1, 14, 'h104,   1,  1, 11, 'h101,  0, 0, 0,         'h3800};
        vt[12] = '{0, 0, 0,       0, 0, 0,      0, 0, 0,        1,  1, 12, 'h102,  0, 0, 0,         'h7000};
        vt[13] = '{0, 0, 0,       0, 0, 0,      0, 0, 0,        1,  1, 13, 'h103,  0, 0, 0,         'h6000};
        vt[14] = '{0, 0, 0,       0, 0, 0,      0, 0, 0,        1,  1, 14, 'h104,  0, 0, 0,         'h4000};
        vt[15] = '{0, 0, 0,       0, 0, 0,      0, 0, 0,        1,  0, 0, 0,       0, 0, 0,         0};
        vt[16] = '{1, 1, 'hA1,    1, 2, 'hB2,   1, 9, 'h99,     1,  1, 1, 'hA1,    1, 2, 'hB2,      0};
        vt[17] = '{1, 9, 'h5,     1, 2, 'hB2,   0, 0, 0,        1,  1, 9, 'h5,     1, 2, 'hB2,      'h200};
        vt[18] = '{0, 0, 0,       0, 0, 0,      0, 0, 0,        1,  0, 0, 0,       0, 0, 0,         0};
        vt[19] = '{1, 9, 'h6,     0, 0, 0,      1, 9, 'h77,     1,  1, 9, 'h6,     0, 0, 0,         0};
        vt[20] = '{0, 0, 0,       0, 0, 0,      0, 0, 0,        1,  1, 9, 'h77,    0, 0, 0,         'h200};
        vt[21] = '{0, 0, 0,       0, 0, 0,      0, 0, 0,        1,  0, 0, 0,       0, 0, 0,         0};
        vt[22] = '{0, 0, 0,       0, 0, 0,      1, 0, 'h55,     1,  0, 0, 0,       0, 0, 0,         0};
        vt[23] = '{0, 0, 0,       0, 0, 0,      0, 0, 0,        1,  0, 0, 0,       0, 0, 0,         0};

        for (int r = 0; r < 32; r++) begin
            obs_rf[r] = '0;
            mdl_rf[r] = '0;
        end
        m_age = 0;
        m_stall = 0;

        // Reset held two cycles with traffic present: no writes, no acceptance.
        drive(1, 1, 5, 'h5A, 1, 6, 'h6A, 1, 7, 'h7A);
        @(negedge clk);
        pre();
        chk("rst1 lu_ready", 32'(lu_ready), 32'(0));
        chk("rst1 rf_wen0", 32'(rf_wen0), 32'(0));
        chk("rst1 rf_wen1", 32'(rf_wen1), 32'(0));
        post();
        pre();
        chk("rst2 lu_ready", 32'(lu_ready), 32'(0));
        chk("rst2 rf_wen0", 32'(rf_wen0), 32'(0));
        chk("rst2 rf_wen1", 32'(rf_wen1), 32'(0));
        chk("rst2 pend_busy", pend_busy, 32'(0));
        chk("rst2 wb_stall", 32'(wb_stall), 32'(0));
        post();

        run_rows(0, 18);
        chk("waw r9 value", obs_rf[9], 32'h5);
        run_rows(19, 23);
        chk("younger lu r9 value", obs_rf[9], 32'h77);

        // Starvation: head r3 blocked by both pipe ports for MAX_WAIT cycles.
        drive(0, 1, 1, 'hA1, 1, 2, 'hB2, 1, 3, 'h33);
        pre(); post();
        for (int k = 0; k < MAX_WAIT; k++) begin
            drive(0, 1, 1, 'hA1, 1, 2, 'hB2, 0, 0, 0);
            pre();
            chk($sformatf("starve%0d wb_stall", k), 32'(wb_stall), 32'(0));
            chk($sformatf("starve%0d pend_busy", k), pend_busy, 32'h8);
            post();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        pre();
        chk("stall raised", 32'(wb_stall), 32'(1));
        chk("stall drain wen0", 32'(rf_wen0), 32'(1));
        chk("stall drain addr", 32'(rf_waddr0), 32'(3));
        chk("stall drain data", rf_wdata0, 32'h33);
        post();
        pre();
        chk("stall released", 32'(wb_stall), 32'(0));
        chk("stall pend clear", pend_busy, 32'(0));
        post();

        // Reset mid-operation discards a queued write.
        drive(0, 1, 1, 'hA1, 1, 2, 'hB2, 1, 4, 'h44);
        pre(); post();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        pre(); post();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        pre();
        chk("midrst pend_busy", pend_busy, 32'(0));
        chk("midrst rf_wen0", 32'(rf_wen0), 32'(0));
        chk("midrst rf_wen1", 32'(rf_wen1), 32'(0));
        post();

        // Randomized traffic against the queue model.
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        pre(); post();
        for (int r = 0; r < 32; r++) begin
            obs_rf[r] = '0;
            mdl_rf[r] = '0;
        end
        for (int n = 0; n < 1500; n++) begin
            int rr, w0, w1;
            rr = ($urandom_range(0, 99) == 0) ? 1 : 0;
            w0 = (!m_stall && $urandom_range(0, 99) < 55) ? 1 : 0;
            w1 = (!m_stall && $urandom_range(0, 99) < 45) ? 1 : 0;
            drive(rr, w0, int'($urandom_range(0, 11)), int'($urandom),
                  w1, int'($urandom_range(0, 11)), int'($urandom),
                  ($urandom_range(0, 99) < 50) ? 1 : 0, int'($urandom_range(0, 11)), int'($urandom));
            pre();
            chk_model();
            post();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < DEPTH + 2; k++) begin
            pre();
            chk_model();
            post();
        end
        for (int r = 0; r < 32; r++) begin
            chk($sformatf("final rf[%0d]", r), obs_rf[r], mdl_rf[r]);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
